// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter: datapath sizes and
// requester indices used to address the per-requester slot arrays.
package regfile_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NREG    = 32;
  localparam int NREQ    = 2;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
endpackage

// File: rtl/reg_decoder.sv
// Combinational ADDR_W-to-NREG one-hot decoder with enable; all-zero when
// disabled. Used for both the write select and the read-side pending check.
module reg_decoder #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   onehot
);
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign onehot[gi] = en && (addr == ADDR_W'(gi));
    end
  endgenerate
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the ALU and memory
// writeback stages: one holding slot each, oldest-first grant, rr tie-break.
module regfile_write_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREG   = regfile_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              regWrite,
  output logic [NREG-1:0]   decOut,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_pending
);
  import regfile_pkg::*;

  logic [NREQ-1:0]   req_valid, ready, accept, grant;
  logic [NREQ-1:0]   slot_full, slot_age, slot_hit;
  logic [ADDR_W-1:0] req_addr  [NREQ];
  logic [DATA_W-1:0] req_data  [NREQ];
  logic [ADDR_W-1:0] slot_addr [NREQ];
  logic [DATA_W-1:0] slot_data [NREQ];

  assign req_valid[REQ_ALU] = alu_valid;
  assign req_valid[REQ_MEM] = mem_valid;
  assign req_addr[REQ_ALU]  = alu_addr;
  assign req_addr[REQ_MEM]  = mem_addr;
  assign req_data[REQ_ALU]  = alu_data;
  assign req_data[REQ_MEM]  = mem_data;
  assign alu_ready          = ready[REQ_ALU];
  assign mem_ready          = ready[REQ_MEM];

  // age = 1 means this entry was accepted strictly before the other slot's.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      localparam int OTHER = NREQ - 1 - gi;
      logic              full_q, full_d, age_q, age_d;
      logic [ADDR_W-1:0] addr_q, addr_d;
      logic [DATA_W-1:0] data_q, data_d;

      assign ready[gi]  = !full_q || grant[gi];
      assign accept[gi] = req_valid[gi] && ready[gi];

      always_comb begin
        full_d = full_q && !grant[gi];
        age_d  = age_q && full_d;
        addr_d = addr_q;
        data_d = data_q;
        if (accept[gi]) begin
          full_d = 1'b1;
          age_d  = 1'b0;
          addr_d = req_addr[gi];
          data_d = req_data[gi];
        end else if (accept[OTHER] && full_d) begin
          age_d  = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          full_q <= 1'b0;
          age_q  <= 1'b0;
          addr_q <= '0;
          data_q <= '0;
        end else begin
          full_q <= full_d;
          age_q  <= age_d;
          addr_q <= addr_d;
          data_q <= data_d;
        end
      end

      assign slot_full[gi] = full_q;
      assign slot_age[gi]  = age_q;
      assign slot_addr[gi] = addr_q;
      assign slot_data[gi] = data_q;
      assign slot_hit[gi]  = full_q && (addr_q == rd_addr);
    end
  endgenerate

  logic rr_q, rr_d;

  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    if (&slot_full) begin
      if (slot_age[REQ_ALU] != slot_age[REQ_MEM]) begin
        grant = slot_age;
      end else begin
        grant[rr_q] = 1'b1;
        rr_d        = !rr_q;
      end
    end else begin
      grant = slot_full;
    end
  end

  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              issue_en;
  logic [NREG-1:0]   issue_onehot;

  assign issue_addr = grant[REQ_MEM] ? slot_addr[REQ_MEM] : slot_addr[REQ_ALU];
  assign issue_data = grant[REQ_MEM] ? slot_data[REQ_MEM] : slot_data[REQ_ALU];
  // Register $0 writes still drain the slot and load wr_data, but never strobe.
  assign issue_en   = (|grant) && (issue_addr != '0);

  reg_decoder #(.ADDR_W(ADDR_W), .NREG(NREG)) u_wr_dec (
    .en     (issue_en),
    .addr   (issue_addr),
    .onehot (issue_onehot)
  );

  logic              regwrite_q, regwrite_d;
  logic [NREG-1:0]   decout_q, decout_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_comb begin
    regwrite_d = issue_en;
    decout_d   = issue_onehot;
    wr_data_d  = (|grant) ? issue_data : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q       <= 1'(REQ_ALU);
      regwrite_q <= 1'b0;
      decout_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      regwrite_q <= regwrite_d;
      decout_q   <= decout_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign regWrite = regwrite_q;
  assign decOut   = decout_q;
  assign wr_data  = wr_data_q;

  logic            rd_nonzero;
  logic [NREG-1:0] rd_onehot;

  assign rd_nonzero = (rd_addr != '0);

  reg_decoder #(.ADDR_W(ADDR_W), .NREG(NREG)) u_rd_dec (
    .en     (rd_nonzero),
    .addr   (rd_addr),
    .onehot (rd_onehot)
  );

  // decOut is non-zero only while regWrite is high, so it doubles as the issued address.
  assign rd_pending = rd_nonzero && ((|slot_hit) || (|(rd_onehot & decout_q)));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes hand-ordered expected writes, a negedge
// monitor pops one per regWrite pulse; directed checks cover ready/pending/reset.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, rd_addr;
  logic [31:0] alu_data, mem_data;
  logic        regWrite, rd_pending;
  logic [31:0] decOut, wr_data;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .regWrite   (regWrite),
    .decOut     (decOut),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_pulses = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic set_req(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (regWrite === 1'b1) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: decOut=0x%08h wr_data=0x%08h, required no write", decOut, wr_data);
        end else begin
          wr_t e;
          logic [31:0] exp_dec;
          e = exp_q.pop_front();
          exp_dec = 32'd1 << e.addr;
          $display("write %0d: decOut=0x%08h wr_data=0x%08h (expected reg %0d data 0x%08h)",
                   n_pulses, decOut, wr_data, e.addr, e.data);
          chk("wr_decOut", decOut, exp_dec);
          chk("wr_data", wr_data, e.data);
          chk("decOut_onehot", 32'($onehot(decOut)), 32'd1);
        end
      end else begin
        chk("idle_decOut", decOut, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, mi, cyc, n0;
    logic a_acc, m_acc;

    reset = 1'b1;
    rd_addr = 5'd5;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_decOut", decOut, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_rd_pending", 32'(rd_pending), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Single write
    set_req(1, 5, 32'hDEADBEEF, 0, 0, 0);
    push(5, 32'hDEADBEEF);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("single_pending_slot", 32'(rd_pending), 32'd1);
    chk("single_no_early_write", 32'(regWrite), 32'd0);
    @(negedge clk);
    #1;
    chk("single_regWrite", 32'(regWrite), 32'd1);
    chk("single_pending_issue", 32'(rd_pending), 32'd1);
    @(negedge clk);
    #1;
    chk("single_one_pulse", 32'(regWrite), 32'd0);
    chk("single_pending_clear", 32'(rd_pending), 32'd0);
    chk("single_data_hold", wr_data, 32'hDEADBEEF);

    // Same-edge collisions: rr starts at alu, then toggles to mem
    push(3, 32'h11);
    push(3, 32'h22);
    set_req(1, 3, 32'h11, 1, 3, 32'h22);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    rd_addr = 5'd3;
    #1;
    chk("coll1_alu_ready", 32'(alu_ready), 32'd1);
    chk("coll1_mem_ready", 32'(mem_ready), 32'd0);
    chk("coll1_pending", 32'(rd_pending), 32'd1);
    repeat (3) @(negedge clk);
    push(3, 32'h44);
    push(3, 32'h33);
    set_req(1, 3, 32'h33, 1, 3, 32'h44);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("coll2_alu_ready", 32'(alu_ready), 32'd0);
    chk("coll2_mem_ready", 32'(mem_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Age order: mem accepted first, alu accepted while mem is granted
    push(7, 32'h77);
    push(7, 32'h70);
    set_req(0, 0, 0, 1, 7, 32'h77);
    @(negedge clk);
    set_req(1, 7, 32'h70, 0, 0, 0);
    chk("age_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_req(0, 0, 0, 1, 5'(20 + i), 32'hA0 + 32'(i));
      chk("stream_mem_ready", 32'(mem_ready), 32'd1);
      push(5'(20 + i), 32'hA0 + 32'(i));
      @(negedge clk);
    end
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Register $0 write is consumed silently
    set_req(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    rd_addr = 5'd0;
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("r0_pending", 32'(rd_pending), 32'd0);
    @(negedge clk);
    #1;
    chk("r0_regWrite", 32'(regWrite), 32'd0);
    chk("r0_decOut", decOut, 32'd0);
    chk("r0_wr_data", wr_data, 32'hFFFFFFFF);
    chk("r0_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);

    // Reset mid-operation: only the first write escapes, buffered ones are dropped
    push(9, 32'hA1);
    set_req(1, 9, 32'hA1, 1, 10, 32'hB1);
    @(negedge clk);
    set_req(1, 11, 32'hA2, 0, 0, 0);
    chk("mid_alu_ready", 32'(alu_ready), 32'd1);
    chk("mid_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    rd_addr = 5'd10;
    #1;
    chk("mid_regWrite", 32'(regWrite), 32'd1);
    chk("mid_pending", 32'(rd_pending), 32'd1);
    reset = 1'b1;
    set_req(1, 12, 32'hBAD0, 1, 13, 32'hBAD1);
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
    chk("mid_rst_decOut", decOut, 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("mid_rst_pending10", 32'(rd_pending), 32'd0);
    rd_addr = 5'd11;
    #1;
    chk("mid_rst_pending11", 32'(rd_pending), 32'd0);
    repeat (5) @(negedge clk);

    // Saturation: both requesters streaming, issue alternates alu/mem
    for (int i = 0; i < 10; i++) begin
      push(5'(1 + i), 32'h1000 + 32'(i));
      push(5'(11 + i), 32'h2000 + 32'(i));
    end
    n0 = n_pulses;
    ai = 0;
    mi = 0;
    cyc = 0;
    while ((ai < 10 || mi < 10) && cyc < 100) begin
      set_req(ai < 10, 5'(1 + ai), 32'h1000 + 32'(ai),
              mi < 10, 5'(11 + mi), 32'h2000 + 32'(mi));
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      @(negedge clk);
      if (a_acc) ai++;
      if (m_acc) mi++;
      cyc++;
    end
    set_req(0, 0, 0, 0, 0, 0);
    chk("sat_all_accepted", 32'(ai + mi), 32'd20);
    repeat (5) @(negedge clk);
    chk("sat_pulses", 32'(n_pulses - n0), 32'd20);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
